// File: rtl/mole_pkg.sv
// mole_pkg: shared state encoding, LFSR constants and score width for the mole sequencer.
package mole_pkg;
  typedef enum logic [1:0] {IDLE, GAP, UP, DONE} state_t;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;
  localparam int SCORE_W = 8;
  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], ^(l & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/mole_sequencer_tick_gen.sv
// tick_gen: prescaler emitting a one-cycle enable every TICK_DIV clocks.
module tick_gen #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(TICK_DIV - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (clear || tick) ? '0 : cnt + W'(1);
endmodule

// File: rtl/mole_sequencer.sv
// mole_sequencer: whack-a-mole round controller; pops moles at pseudo-random holes,
// scores hits, counts misses and shortens up-time as the round goes on.
module mole_sequencer
  import mole_pkg::*;
#(
  parameter int TICK_DIV      = 1_000_000,
  parameter int NUM_HOLES     = 8,
  parameter int GAP_TICKS     = 30,
  parameter int UP_TICKS_INIT = 100,
  parameter int UP_TICKS_MIN  = 20,
  parameter int UP_STEP       = 5,
  parameter int ROUND_MOLES   = 30
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_HOLES-1:0] hit,
  output logic [NUM_HOLES-1:0] mole,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   misses,
  output logic                 busy,
  output logic                 done
);
  localparam int HB = $clog2(NUM_HOLES);
  state_t state;
  logic [7:0] lfsr, up_time, count;
  logic [15:0] tcnt, last;
  logic [HB-1:0] hole, cand, next_hole;
  logic tick, tick_end, struck, last_mole;
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock(clock),
    .reset(reset),
    .clear(state == IDLE),
    .tick (tick)
  );
  // hole holds the previously lit hole, so a repeat candidate is bumped by one
  assign cand      = lfsr[HB-1:0];
  assign next_hole = (cand == hole) ? cand + HB'(1) : cand;
  assign last      = (state == GAP) ? 16'(GAP_TICKS - 1) : {8'd0, up_time - 8'd1};
  assign tick_end  = tick && (tcnt == last);
  assign struck    = hit[hole];
  assign last_mole = (count + 8'd1) == 8'(ROUND_MOLES);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state   <= IDLE;
      lfsr    <= LFSR_SEED;
      up_time <= 8'(UP_TICKS_INIT);
      count   <= '0;
      tcnt    <= '0;
      hole    <= '0;
      mole    <= '0;
      score   <= '0;
      misses  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      lfsr <= lfsr_next(lfsr);
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state   <= GAP;
          score   <= '0;
          misses  <= '0;
          count   <= '0;
          tcnt    <= '0;
          up_time <= 8'(UP_TICKS_INIT);
          busy    <= 1'b1;
        end
        GAP: if (tick_end) begin
          state <= UP;
          hole  <= next_hole;
          mole  <= NUM_HOLES'(1) << next_hole;
          tcnt  <= '0;
        end else if (tick) tcnt <= tcnt + 16'd1;
        UP: if (struck || tick_end) begin
          mole  <= '0;
          tcnt  <= '0;
          count <= count + 8'd1;
          if (struck) begin
            score   <= (score == 8'hFF) ? score : score + 8'd1;
            up_time <= (int'(up_time) >= UP_TICKS_MIN + UP_STEP) ? up_time - 8'(UP_STEP) : 8'(UP_TICKS_MIN);
          end else misses <= misses + 8'd1;
          state <= last_mole ? DONE : GAP;
          busy  <= !last_mole;
          done  <= last_mole;
        end else if (tick) tcnt <= tcnt + 16'd1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/mole_sequencer.md
# mole_sequencer

Game-round controller for the Whack-a-Mole design. It runs a prescaler that emits one-cycle tick enables instead of a toggled clock, then sequences mole pop-ups at pseudo-random holes. It scores player hits, counts misses and shortens mole up-time as the round progresses. It sits between the debounced button/switch inputs and the LED and 7-segment drivers, all on the single system clock.

## Interface
- `TICK_DIV`, 1_000_000: system clocks per game tick (100 Hz at 100 MHz); ≥ 2.
- `NUM_HOLES`, 8: hole count; power of two, 2..16.
- `GAP_TICKS`, 30: ticks with no mole between pop-ups; ≥ 1.
- `UP_TICKS_INIT`, 100: initial mole up-time in ticks.
- `UP_TICKS_MIN`, 20: floor for up-time; 1 ≤ MIN ≤ INIT ≤ 255.
- `UP_STEP`, 5: up-time decrement per successful hit.
- `ROUND_MOLES`, 30: pop-ups per round; 1..255.
- `clock` in 1: system clock; all logic on posedge.
- `reset` in 1: asynchronous, active-high; forces IDLE and clears all registers.
- `start` in 1: one-cycle pulse; begins a round; honoured only in IDLE.
- `hit` in NUM_HOLES: one-cycle pulses from debouncers, already synchronous; bit i = hole i struck.
- `mole` out NUM_HOLES: one-hot lit hole while UP, else 0.
- `score` out 8: successful hits this round, saturating at 255.
- `misses` out 8: expired moles this round.
- `busy` out 1: high in GAP and UP.
- `done` out 1: one-cycle pulse at round end.

## Operation
- Reset values: mole=0, score=0, misses=0, busy=0, done=0. LFSR=8'hA5, up_time=UP_TICKS_INIT, state IDLE.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every clock and never takes the value 0. Candidate hole is the low log2(NUM_HOLES) bits. If the candidate equals the previous hole, use candidate+1 mod NUM_HOLES.
- States:
  - IDLE: on start, clear score, misses and mole count, set up_time=UP_TICKS_INIT, clear tick prescaler and tick counter, go to GAP.
  - GAP: count ticks. On the GAP_TICKS-th tick, latch the hole, clear the tick counter and go to UP.
  - UP: mole shows the latched hole.
    - hit[hole]=1: score+1, up_time=max(up_time−UP_STEP, UP_TICKS_MIN), increment mole count.
    - Otherwise, on the up_time-th tick: misses+1, increment mole count.
    - After either event: go to DONE if mole count = ROUND_MOLES, else GAP.
  - DONE: done=1 for this one cycle, then IDLE.
- Hits on other holes, and all hits outside UP, are ignored with no penalty.
- Hit and expiry tick in the same cycle: the hit wins; misses is unchanged.
- start outside IDLE is ignored. score and misses hold after DONE until the next start.
- up_time arithmetic is 8-bit unsigned. Subtraction clamps at UP_TICKS_MIN and never wraps.

## Timing
- The prescaler tick is high for one clock when the prescaler is at TICK_DIV−1, then the prescaler wraps to 0.
- start in cycle N: busy=1 from N+1. The first tick arrives at N+TICK_DIV.
- mole is registered. It rises the cycle after the GAP→UP transition edge and falls the cycle after the hit or expiry edge.
- score and misses update on the same edge that leaves UP.
- done is asserted during the DONE cycle. busy drops on the same edge that enters DONE.
- Asynchronous reset mid-round kills the round at once: mole=0 and no done pulse.

## Structure
- `mole_pkg` holds the state enum (IDLE, GAP, UP, DONE), the LFSR seed and tap constants, and the 8-bit score width.
- Sub-module `tick_gen` is the prescaler. Inputs: clock, reset, synchronous clear. Output: one-cycle tick enable. It is parameterised by TICK_DIV.

## Test plan
All scenarios use TICK_DIV=4, GAP_TICKS=2, UP_TICKS_INIT=3, UP_TICKS_MIN=1, UP_STEP=1, ROUND_MOLES=3.
- Reset then idle 50 cycles -> mole=0, score=0, misses=0, busy=0, no done.
- start, no hits -> each mole is lit for exactly 12 cycles with 8-cycle gaps. misses=3, score=0, one done pulse, no hole repeated back-to-back.
- start, strike the lit hole 2 cycles after each rise -> score=3, misses=0, up_time sequence 3→2→1.
- Strike a wrong hole while a mole is up, then strike the right hole on the expiry tick -> wrong hit ignored, score+1, misses+0.
- start pulsed again mid-round -> ignored, the round finishes normally. Assert reset mid-UP -> mole=0 next sample, state IDLE, no done.
- Run 10 rounds back-to-back -> score and misses hold after each done and clear on the next start.
